instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Encoder/loader for the 8-bit instruction ROM image.
- Accepts one decoded instruction per handshake as fields (opcode, register selectors, immediate, flag).
- Packs the fields into the 8-bit word the fetch/decode stage expects and writes them to consecutive instruction-memory addresses.
- Sits between the test/boot program source and the instruction memory. It is the encode direction of the decode path.

Parameters:
- BASE_ADDR, 0: address of the first word written after start.
- DEPTH, 256: maximum number of words per load; range 1..65536.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new load from BASE_ADDR.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder accepts bundle this cycle.
- in_opcode  in  4  opcode: LB=0, LHB=1, JMP=2, STR=3, LIM=4, MVB=5, MVF=6, ADD=7, SUB=8, SFT=9, BNE=A, BEQ=B, BLT=C, INC=D, HALT=E, TBA=F.
- in_ra  in  3  I-form register, or M-form source register.
- in_rb  in  3  M-form destination register.
- in_imm  in  3  immediate, C-form only.
- in_imm_flag  in  1  immediate flag / C-form output-register select.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  16  write address.
- mem_wdata  out  8  encoded instruction.
- busy  out  1  high in LOAD.
- done  out  1  load ended (HALT written or memory full).
- overflow  out  1  load ended by DEPTH exhausted without HALT.
- err  out  1  illegal register field seen; load aborted.
- word_count  out  16  words written in current load.

Behaviour:
- Reset: state IDLE. in_ready, mem_we, busy, done, overflow, err = 0. mem_addr = BASE_ADDR; mem_wdata = 0; word_count = 0.
- Format is set by opcode:
  - C-form: JMP, LIM.
  - I-form: SFT, INC.
  - X-form: HALT, TBA.
  - M-form: all other opcodes.
- Encoding, with instr[7:4] = opcode:
  - C: instr[3:1] = in_imm, instr[0] = in_imm_flag.
  - I: instr[3:1] = in_ra, instr[0] = in_imm_flag.
  - M: instr[3:2] = in_ra[1:0], instr[1:0] = in_rb[1:0]. Legal only if in_ra[2] = 0 and in_rb[2] = 1; otherwise illegal.
  - X: instr[3:0] = 0000.
  - Fields unused by the format are ignored and never cause an error.
- States:
  - IDLE: in_ready = 0. start → LOAD, clearing word_count, done, overflow and err. Write pointer set to BASE_ADDR.
  - LOAD: in_ready = 1. Accept occurs when in_valid & in_ready.
  - DONE: in_ready = 0. start → LOAD, with the same clearing as from IDLE.
  - ERR: in_ready = 0; err held at 1. start → LOAD, with the same clearing as from IDLE.
- Legal accept in cycle N:
  - mem_we = 1 in cycle N+1, with mem_addr = pointer and mem_wdata = encoded word.
  - Pointer and word_count increment in cycle N+1.
  - Throughput is one word per cycle in LOAD.
- Accepting HALT: the word is written. State → DONE at N+1; done = 1 at N+1.
- Accepting the DEPTH-th word when it is not HALT: the word is written. State → DONE; done = 1 and overflow = 1 at N+1.
- HALT as the DEPTH-th word: done = 1, overflow = 0.
- Illegal M-form accept: no write occurs. word_count is unchanged. State → ERR; err = 1 at N+1.
- mem_we = 0 whenever no accept occurred in the previous cycle. mem_addr and mem_wdata hold their last values.
- start while in LOAD is ignored. start in the same cycle as in_valid in IDLE/DONE/ERR is not an accept, because in_ready = 0.
- Pointer arithmetic is 16-bit modulo. BASE_ADDR + DEPTH may wrap past FFFF, and the address wraps to 0000.
- reset mid-load:
  - Takes effect on the next edge. Returns to reset values.
  - Any write strobe due in that cycle is suppressed; mem_we = 0.

Test Plan:
- start; LIM imm=5 flag=1; ADD ra=1 rb=6; INC ra=3 flag=0; HALT, back-to-back → mem_we on 4 consecutive cycles. Addr 0..3. Data 0x4B, 0x76, 0xD6, 0xE0. done=1 and word_count=4 on the HALT write cycle. in_ready=0 afterwards.
- M-form illegal: start; SUB ra=4 rb=5 → no mem_we, err=1, ERR state. Then start; JMP imm=2 flag=0 → write 0x24 at addr 0, err cleared.
- DEPTH=4, BASE_ADDR=16'hFFFE: four STR ra=0 rb=7 words → addresses FFFE, FFFF, 0000, 0001. Data 0x33 each. done=1, overflow=1.
- Bubbles and ignored fields: in_valid toggling 1,0,1 with SFT ra=7 flag=1 (imm=7, rb=0 garbage) → writes 0x9F only on cycles following accepts. mem_we=0 on the bubble.
- Reset mid-load: accept ADD ra=0 rb=4 (0x70), assert reset the same cycle → no write, outputs at reset values. start afterwards resumes at BASE_ADDR.
- start pulsed during LOAD and in DONE: ignored in LOAD (pointer unchanged). In DONE, restarts at BASE_ADDR with word_count=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction ROM loader: packs decoded instruction fields into the 8-bit
// fetch/decode word and streams them into consecutive instruction-memory addresses.
module instr_encoder #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          DEPTH     = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_opcode,
   input  logic [2:0]  in_ra,
   input  logic [2:0]  in_rb,
   input  logic [2:0]  in_imm,
   input  logic        in_imm_flag,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        err,
   output logic [15:0] word_count
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

   typedef enum logic [3:0] {
      OP_LB,  OP_LHB, OP_JMP, OP_STR, OP_LIM, OP_MVB, OP_MVF, OP_ADD,
      OP_SUB, OP_SFT, OP_BNE, OP_BEQ, OP_BLT, OP_INC, OP_HALT, OP_TBA
   } opcode_t;

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   state_t      state;
   logic [15:0] ptr;
   logic [7:0]  enc_word;
   logic        enc_legal;
   logic        last_word;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      enc_word  = {in_opcode, 4'b0000};
      enc_legal = 1'b1;
      case (opcode_t'(in_opcode))
         OP_JMP, OP_LIM:  enc_word[3:0] = {in_imm, in_imm_flag};
         OP_SFT, OP_INC:  enc_word[3:0] = {in_ra, in_imm_flag};
         OP_HALT, OP_TBA: enc_word[3:0] = 4'b0000;
         default: begin
            // M-form: source must be r0-r3, destination r4-r7; only the low bits are stored.
            enc_word[3:0] = {in_ra[1:0], in_rb[1:0]};
            enc_legal     = !in_ra[2] && in_rb[2];
         end
      endcase
   end

   // Widened compare so DEPTH = 65536 still terminates the load.
   assign last_word = (({1'b0, word_count} + 17'd1) == DEPTH_W);
   assign busy      = in_ready;

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= 8'h00;
         ptr        <= BASE_ADDR;
         word_count <= 16'h0000;
         done       <= 1'b0;
         overflow   <= 1'b0;
         err        <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            LOAD: begin
               if (in_valid) begin
                  if (!enc_legal) begin
                     state    <= ERR;
                     in_ready <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     mem_we     <= 1'b1;
                     mem_addr   <= ptr;
                     mem_wdata  <= enc_word;
                     ptr        <= ptr + 16'd1;
                     word_count <= word_count + 16'd1;
                     if (opcode_t'(in_opcode) == OP_HALT) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                     end else if (last_word) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                        overflow <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               if (start) begin
                  state      <= LOAD;
                  in_ready   <= 1'b1;
                  ptr        <= BASE_ADDR;
                  word_count <= 16'h0000;
                  done       <= 1'b0;
                  overflow   <= 1'b0;
                  err        <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
